backend_pipe_ctrl: RTL and testbench
====================================

# backend_pipe_ctrl

Central stall/clear scheduler for the two lock-stepped backend pipelines (pipe 0 = main pipe with BPF/LSU/CSR, pipe 1 = ALU-only; pipe 0 is older within an issue pair). Collects per-stage stall and clear requests plus revert markers from both pipes. Produces the shared stall vector, the per-pipe clear vectors, issue hold/kill and a single frontend-flush pulse. Owns the revert drain FSM and two performance counters.

## Interface
- `CNT_W`, default 32: width of the stall-cycle counter.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ex_stall_req_i` / `m1_stall_req_i` / `m2_stall_req_i`  in  [1:0] each  per-pipe stall request, indexed by pipe.
- `ex_clr_req_i`  in  [1:0]  branch-mispredict flush from EX, indexed by pipe.
- `m2_clr_req_i`  in  [1:0]  exception/redirect flush from M2, indexed by pipe.
- `revert_vector_i`  in  [1:0][3:0]  per-pipe revert markers; bit order {wb,m2,m1,ex}.
- `stall_vec_o`  out  [2:0]  shared stall; bit 0 = ex, 1 = m1, 2 = m2.
- `clr_vec_o`  out  [1:0][2:0]  per-pipe clear; bit s kills the instruction leaving stage s.
- `issue_stall_o`  out  1  issue must hold its pair.
- `issue_kill_o`  out  1  issue must drop its pair (issue_i forced low).
- `frontend_flush_o`  out  1  one-cycle redirect pulse to the frontend.
- `stall_cycles_o`  out  CNT_W  count of cycles with stall_vec_o[0]=1, saturating.
- `flush_count_o`  out  16  count of frontend_flush_o pulses, saturating.

## Operation
- Stall chaining is combinational:
  - s2 = |m2_stall_req_i
  - s1 = s2 | |m1_stall_req_i
  - s0 = s1 | |ex_stall_req_i
  - stall_vec_o = {s2,s1,s0}
- A clear into a stalled stage has no effect. The controller therefore gates and queues clears as described below.
- M2 flush, highest priority, from pipe p:
  - Clear bits 0 and 1 of both pipes.
  - If p=0, also set clr_vec_o[1][2]. The faulting instruction itself completes.
  - Assert issue_kill_o and frontend_flush_o in the same cycle.
  - Abort any pending EX flush and any drain; next state is RUN.
- EX flush from pipe p, accepted only when s1=0 and no M2 flush:
  - If p=0, set clr_vec_o[1][0]. If p=1, no pipe clear.
  - Assert issue_kill_o and frontend_flush_o for exactly one cycle.
  - If the request arrives while s1=1, latch `pend_ex_flush` and the pipe id. Apply the flush in the first cycle with s1=0, then clear the latch.
  - Further EX requests while pending are ignored.
- Drain FSM, states RUN, DRAIN, REDIRECT:
  - RUN → DRAIN when any revert_vector_i[p][0] is 1 and stall_vec_o[0]=0.
  - DRAIN: issue_stall_o=1. Stay until any revert_vector_i[p][3] is 1, then go to REDIRECT.
  - REDIRECT: frontend_flush_o=1 and issue_kill_o=1 for one cycle, then RUN.
  - An M2 flush in DRAIN or REDIRECT goes to RUN. Its own single pulse is the only flush pulse (no double pulse).
- issue_stall_o = s0 | (state≠RUN).
- Counters:
  - stall_cycles_o increments while s0=1.
  - flush_count_o increments on each frontend_flush_o.
  - Both saturate at all-ones.

## Timing
- stall_vec_o, clr_vec_o, issue_stall_o, issue_kill_o and frontend_flush_o are combinational from inputs and registered state; zero latency.
- Reset values:
  - state=RUN, pend_ex_flush=0, both counters 0.
  - With all inputs 0, every output is 0.
- A reset asserted mid-drain or with a flush pending discards it; the first post-reset cycle is RUN.
- Simultaneous events:
  - An M2 flush and an EX flush in the same cycle produce one pulse, the M2 flush.
  - EX flushes from both pipes in the same cycle: pipe 0 wins, since pipe 1's instruction is cleared.
- frontend_flush_o is never high two consecutive cycles for the same event.

## Structure
- Shared package `pipeline_ctrl_pkg`: the `drain_state_t` enum and `PIPE_NUM=2` / `STAGE_NUM=3`, reused by backend_pipeline instances.
- One sub-module `sat_counter` (parameter WIDTH; inputs inc, rst_n; output value), instantiated twice.

## Test plan
- Stall chain: m1_stall_req_i=2'b10 → stall_vec_o=3'b011, issue_stall_o=1, stall_cycles_o +1 per cycle.
- Pipe-0 EX flush with no stall → same cycle clr_vec_o[1]=3'b001, frontend_flush_o=1 for 1 cycle, flush_count_o=1.
- EX flush while m2_stall_req_i=2'b01 held 3 cycles → no pulse for 3 cycles; on release, one pulse and clr_vec_o[1][0]=1.
- Revert: revert_vector_i[0]=4'b0001, then 4'b1000 three cycles later → issue_stall_o high 3 cycles, then a REDIRECT pulse, then RUN.
- M2 flush from pipe 0 during DRAIN → clr_vec_o[0]=3'b011, clr_vec_o[1]=3'b111, a single pulse, state RUN next cycle.
- Saturation: preload counters via 2^16 flushes → flush_count_o holds 16'hFFFF; rst_n=0 for one cycle → counters 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared pipeline-control types and sizes
package pipeline_ctrl_pkg;

  localparam int PIPE_NUM  = 2;
  localparam int STAGE_NUM = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } drain_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Advance on inc, holding at all-ones once reached.
  always_comb begin
    value_d = value_q;
    if (inc && (value_q != {WIDTH{1'b1}})) begin
      value_d = value_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/backend_pipe_ctrl.sv
// rtl/backend_pipe_ctrl.sv - stall/clear scheduler for the two lock-stepped backend pipes
module backend_pipe_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ex_stall_req_i,
  input  logic [1:0]       m1_stall_req_i,
  input  logic [1:0]       m2_stall_req_i,
  input  logic [1:0]       ex_clr_req_i,
  input  logic [1:0]       m2_clr_req_i,
  input  logic [1:0][3:0]  revert_vector_i,
  output logic [2:0]       stall_vec_o,
  output logic [1:0][2:0]  clr_vec_o,
  output logic             issue_stall_o,
  output logic             issue_kill_o,
  output logic             frontend_flush_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [15:0]      flush_count_o
);

  drain_state_t state_q, state_d;
  logic         pend_ex_flush_q, pend_ex_flush_d;
  logic         pend_pipe_q, pend_pipe_d;

  logic s0, s1, s2;
  logic m2_flush;
  logic ex_req;
  logic ex_req_pipe;
  logic ex_fire;
  logic ex_fire_pipe;
  logic revert_start;
  logic revert_done;
  logic revert_mid_unused;

  // Stall chains downward: a stalled later stage holds every earlier stage.
  always_comb begin
    s2 = |m2_stall_req_i;
    s1 = s2 | (|m1_stall_req_i);
    s0 = s1 | (|ex_stall_req_i);
  end

  assign stall_vec_o = {s2, s1, s0};

  assign m2_flush     = |m2_clr_req_i;
  assign ex_req       = |ex_clr_req_i;
  // Pipe 0 is older, so its request covers a simultaneous one from pipe 1.
  assign ex_req_pipe  = ~ex_clr_req_i[0];
  assign revert_start = revert_vector_i[0][0] | revert_vector_i[1][0];
  assign revert_done  = revert_vector_i[0][3] | revert_vector_i[1][3];
  assign revert_mid_unused = |{revert_vector_i[1][2:1], revert_vector_i[0][2:1]};

  // EX flush gating: fire when M1/M2 are free, otherwise park one request until they are.
  always_comb begin
    ex_fire         = 1'b0;
    ex_fire_pipe    = 1'b0;
    pend_ex_flush_d = pend_ex_flush_q;
    pend_pipe_d     = pend_pipe_q;
    if (m2_flush) begin
      pend_ex_flush_d = 1'b0;
    end else if (pend_ex_flush_q) begin
      if (!s1) begin
        ex_fire         = 1'b1;
        ex_fire_pipe    = pend_pipe_q;
        pend_ex_flush_d = 1'b0;
      end
    end else if (ex_req) begin
      if (!s1) begin
        ex_fire      = 1'b1;
        ex_fire_pipe = ex_req_pipe;
      end else begin
        pend_ex_flush_d = 1'b1;
        pend_pipe_d     = ex_req_pipe;
      end
    end
  end

  // Drain FSM next state; an M2 flush always returns to RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:      if (revert_start && !s0) state_d = ST_DRAIN;
      ST_DRAIN:    if (revert_done) state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
    if (m2_flush) begin
      state_d = ST_RUN;
    end
  end

  // State and pending-flush registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_RUN;
      pend_ex_flush_q <= 1'b0;
      pend_pipe_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      pend_ex_flush_q <= pend_ex_flush_d;
      pend_pipe_q     <= pend_pipe_d;
    end
  end

  // Clear vectors, issue control and the single combined redirect pulse.
  always_comb begin
    clr_vec_o = '0;
    if (m2_flush) begin
      clr_vec_o[0][1:0] = 2'b11;
      clr_vec_o[1][1:0] = 2'b11;
      clr_vec_o[1][2]   = m2_clr_req_i[0];
    end else if (ex_fire && !ex_fire_pipe) begin
      clr_vec_o[1][0] = 1'b1;
    end
    frontend_flush_o = m2_flush | ex_fire | (state_q == ST_REDIRECT);
    issue_kill_o     = frontend_flush_o;
    issue_stall_o    = s0 | (state_q != ST_RUN);
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (s0),
    .value (stall_cycles_o)
  );

  sat_counter #(.WIDTH(16)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (frontend_flush_o),
    .value (flush_count_o)
  );

endmodule

// File: tb/tb_backend_pipe_ctrl.sv
// tb/tb_backend_pipe_ctrl.sv - self-checking bench for backend_pipe_ctrl
module tb_backend_pipe_ctrl;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       ex_st, m1_st, m2_st, ex_clr, m2_clr;
  logic [1:0][3:0]  rev;
  logic [2:0]       stall_vec;
  logic [1:0][2:0]  clr_vec;
  logic             issue_stall, issue_kill, fflush;
  logic [31:0]      stall_cycles;
  logic [15:0]      flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  backend_pipe_ctrl #(.CNT_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_stall_req_i   (ex_st),
    .m1_stall_req_i   (m1_st),
    .m2_stall_req_i   (m2_st),
    .ex_clr_req_i     (ex_clr),
    .m2_clr_req_i     (m2_clr),
    .revert_vector_i  (rev),
    .stall_vec_o      (stall_vec),
    .clr_vec_o        (clr_vec),
    .issue_stall_o    (issue_stall),
    .issue_kill_o     (issue_kill),
    .frontend_flush_o (fflush),
    .stall_cycles_o   (stall_cycles),
    .flush_count_o    (flush_count)
  );

  typedef struct {
    logic [1:0] ex_st, m1_st, m2_st, ex_clr, m2_clr;
    logic [2:0] sv;
    logic [5:0] clr;
    logic       is, kill, fl;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic zero_inputs();
    ex_st = 0; m1_st = 0; m2_st = 0; ex_clr = 0; m2_clr = 0; rev = '0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    zero_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 6'b000_000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 3'b011, 6'b000_000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 6'b000_000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 3'b111, 6'b000_000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 6'b001_000, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 3'b000, 6'b000_000, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 3'b000, 6'b001_000, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 6'b111_011, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 6'b011_011, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 3'b000, 6'b111_011, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 3'b001, 6'b001_000, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    zero_inputs();
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("reset_stall_vec", 32'(stall_vec), 32'd0);
    chk("reset_clr_vec", 32'(clr_vec), 32'd0);
    chk("reset_issue_stall", 32'(issue_stall), 32'd0);
    chk("reset_issue_kill", 32'(issue_kill), 32'd0);
    chk("reset_flush", 32'(fflush), 32'd0);
    chk("reset_stall_cnt", stall_cycles, 32'd0);
    chk("reset_flush_cnt", 32'(flush_count), 32'd0);

    // Combinational table
    for (int i = 0; i < 11; i++) begin
      tick();
      ex_st = vecs[i].ex_st; m1_st = vecs[i].m1_st; m2_st = vecs[i].m2_st;
      ex_clr = vecs[i].ex_clr; m2_clr = vecs[i].m2_clr;
      #1;
      chk($sformatf("vec%0d_stall_vec", i), 32'(stall_vec), 32'(vecs[i].sv));
      chk($sformatf("vec%0d_clr_vec", i), 32'(clr_vec), 32'(vecs[i].clr));
      chk($sformatf("vec%0d_issue_stall", i), 32'(issue_stall), 32'(vecs[i].is));
      chk($sformatf("vec%0d_issue_kill", i), 32'(issue_kill), 32'(vecs[i].kill));
      chk($sformatf("vec%0d_flush", i), 32'(fflush), 32'(vecs[i].fl));
    end

    // Stall counter: three stalled cycles
    do_reset();
    tick(); m1_st = 2'b10;
    tick(); tick();
    tick(); m1_st = 2'b00;
    #1;
    chk("stall_cnt_3", stall_cycles, 32'd3);

    // Single pipe-0 EX flush
    do_reset();
    tick(); ex_clr = 2'b01;
    #1;
    chk("exfl_clr", 32'(clr_vec), 32'b001_000);
    chk("exfl_pulse", 32'(fflush), 32'd1);
    tick(); ex_clr = 2'b00;
    #1;
    chk("exfl_pulse_end", 32'(fflush), 32'd0);
    chk("exfl_count", 32'(flush_count), 32'd1);

    // EX flush deferred behind an M2 stall
    do_reset();
    tick(); m2_st = 2'b01; ex_clr = 2'b01;
    #1;
    chk("pend_c0_flush", 32'(fflush), 32'd0);
    chk("pend_c0_clr", 32'(clr_vec), 32'd0);
    tick(); ex_clr = 2'b00;
    #1;
    chk("pend_c1_flush", 32'(fflush), 32'd0);
    tick();
    #1;
    chk("pend_c2_flush", 32'(fflush), 32'd0);
    tick(); m2_st = 2'b00;
    #1;
    chk("pend_release_flush", 32'(fflush), 32'd1);
    chk("pend_release_clr", 32'(clr_vec), 32'b001_000);
    tick();
    #1;
    chk("pend_after_flush", 32'(fflush), 32'd0);
    chk("pend_count", 32'(flush_count), 32'd1);

    // Revert drain and redirect
    do_reset();
    tick(); rev[0] = 4'b0001;
    #1;
    chk("rev_c0_stall", 32'(issue_stall), 32'd0);
    tick(); rev[0] = 4'b0000;
    #1;
    chk("rev_c1_stall", 32'(issue_stall), 32'd1);
    chk("rev_c1_flush", 32'(fflush), 32'd0);
    tick();
    #1;
    chk("rev_c2_stall", 32'(issue_stall), 32'd1);
    tick(); rev[0] = 4'b1000;
    #1;
    chk("rev_c3_stall", 32'(issue_stall), 32'd1);
    chk("rev_c3_flush", 32'(fflush), 32'd0);
    tick(); rev[0] = 4'b0000;
    #1;
    chk("rev_redirect_flush", 32'(fflush), 32'd1);
    chk("rev_redirect_kill", 32'(issue_kill), 32'd1);
    tick();
    #1;
    chk("rev_run_flush", 32'(fflush), 32'd0);
    chk("rev_run_stall", 32'(issue_stall), 32'd0);
    chk("rev_count", 32'(flush_count), 32'd1);

    // M2 flush from pipe 0 during DRAIN
    do_reset();
    tick(); rev[0] = 4'b0001;
    tick(); rev[0] = 4'b0000; m2_clr = 2'b01;
    #1;
    chk("m2drain_clr", 32'(clr_vec), 32'b111_011);
    chk("m2drain_flush", 32'(fflush), 32'd1);
    tick(); m2_clr = 2'b00;
    #1;
    chk("m2drain_next_flush", 32'(fflush), 32'd0);
    chk("m2drain_next_stall", 32'(issue_stall), 32'd0);
    chk("m2drain_count", 32'(flush_count), 32'd1);

    // Reset discards a pending EX flush
    do_reset();
    tick(); m2_st = 2'b01; ex_clr = 2'b01;
    tick(); ex_clr = 2'b00;
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1; m2_st = 2'b00;
    #1;
    chk("rst_pend_flush", 32'(fflush), 32'd0);

    // Reset discards a drain
    tick(); rev[0] = 4'b0001;
    tick(); rev[0] = 4'b0000;
    #1;
    chk("rst_drain_pre", 32'(issue_stall), 32'd1);
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    #1;
    chk("rst_drain_post", 32'(issue_stall), 32'd0);

    // Flush counter saturation, then reset
    do_reset();
    tick(); ex_clr = 2'b01;
    repeat (65540) tick();
    ex_clr = 2'b00;
    #1;
    chk("sat_flush_cnt", 32'(flush_count), 32'h0000_FFFF);
    chk("sat_stall_cnt", stall_cycles, 32'd0);
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    #1;
    chk("sat_reset_cnt", 32'(flush_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
